// File: rtl/upsp_ac_rbuf.sv
// Read-side buffer from access-control to the up-sampling core: fetches pixels UPSTR..UPENDR into a FIFO.
// Define UPSP_RBUF_LAST_EN to add a per-entry upsp_rlast flag marking the final pixel of the window.
module upsp_ac_rbuf #(
  parameter int CRF_DATA_WIDTH  = 32,
  parameter int UPSP_DATA_WIDTH = 24,
  parameter int DEPTH           = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CRF_DATA_WIDTH-1:0]    UPSTR,
  input  logic [CRF_DATA_WIDTH-1:0]    UPENDR,
  input  logic                         start,
  input  logic                         ac_upsp_rvalid,
  input  logic [UPSP_DATA_WIDTH-1:0]   ac_upsp_rdata,
  output logic                         upsp_ac_rready,
  output logic                         upsp_rvalid,
  output logic [UPSP_DATA_WIDTH-1:0]   upsp_rdata,
  input  logic                         upsp_rready,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   level,
`ifdef UPSP_RBUF_LAST_EN
  output logic                         upsp_rlast,
`endif
  output logic [1:0]                   dbg_state
);

  // Handshakes: a beat moves on a channel in the cycle where valid && ready at the rising edge;
  // valid never waits on ready, and upsp_rvalid/upsp_rdata hold steady until the beat is taken.

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = CRF_DATA_WIDTH;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        total_q, total_d;
  logic [CW-1:0]        acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]        dlv_cnt_q, dlv_cnt_d;
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 err_q, err_d;
  logic [UPSP_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                 accept, deliver;

  // rready depends only on registered state, never on ac_upsp_rvalid.
  assign upsp_ac_rready = (state_q == ST_RUN) && (level_q < DEPTH_L) && (acc_cnt_q < total_q);
  assign accept         = ac_upsp_rvalid && upsp_ac_rready;
  assign upsp_rvalid    = (level_q != '0);
  assign deliver        = upsp_rvalid && upsp_rready;
  assign upsp_rdata     = upsp_rvalid ? mem_q[rptr_q] : '0;
  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;
  assign level          = level_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    acc_cnt_d = accept  ? acc_cnt_q + CW'(1) : acc_cnt_q;
    dlv_cnt_d = deliver ? dlv_cnt_q + CW'(1) : dlv_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (UPENDR >= UPSTR) begin
            total_d   = UPENDR - UPSTR + CW'(1);
            acc_cnt_d = '0;
            dlv_cnt_d = '0;
            state_d   = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN:   if (accept && (acc_cnt_q + CW'(1) == total_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (deliver && (dlv_cnt_q + CW'(1) == total_q)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({accept, deliver})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      acc_cnt_q <= '0;
      dlv_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      acc_cnt_q <= acc_cnt_d;
      dlv_cnt_q <= dlv_cnt_d;
      level_q   <= level_d;
      err_q     <= err_d;
      if (accept)  wptr_q <= wptr_q + PW'(1);
      if (deliver) rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage is not reset; read data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= ac_upsp_rdata;
  end

`ifdef UPSP_RBUF_LAST_EN
  logic last_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (accept) last_mem_q[wptr_q] <= (acc_cnt_q + CW'(1) == total_q);
  end

  assign upsp_rlast = upsp_rvalid ? last_mem_q[rptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_upsp_ac_rbuf.sv
// Directed bench for upsp_ac_rbuf: accepted ac beats feed an expected queue, delivered upsp beats are checked against it.
module tb_upsp_ac_rbuf;
  localparam int CW = 32;
  localparam int UW = 24;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH+1);

  logic          clk, rst_n;
  logic [CW-1:0] UPSTR, UPENDR;
  logic          start;
  logic          ac_upsp_rvalid;
  logic [UW-1:0] ac_upsp_rdata;
  logic          upsp_ac_rready;
  logic          upsp_rvalid;
  logic [UW-1:0] upsp_rdata;
  logic          upsp_rready;
  logic          busy, done, err;
  logic [LW-1:0] level;
  logic [1:0]    dbg_state;
`ifdef UPSP_RBUF_LAST_EN
  logic          upsp_rlast;
`endif

  upsp_ac_rbuf #(.CRF_DATA_WIDTH(CW), .UPSP_DATA_WIDTH(UW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .UPSTR          (UPSTR),
    .UPENDR         (UPENDR),
    .start          (start),
    .ac_upsp_rvalid (ac_upsp_rvalid),
    .ac_upsp_rdata  (ac_upsp_rdata),
    .upsp_ac_rready (upsp_ac_rready),
    .upsp_rvalid    (upsp_rvalid),
    .upsp_rdata     (upsp_rdata),
    .upsp_rready    (upsp_rready),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .level          (level),
`ifdef UPSP_RBUF_LAST_EN
    .upsp_rlast     (upsp_rlast),
`endif
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [UW-1:0] exp_q[$];
  logic [UW-1:0] ac_dat_r;
  logic          pending_acc = 1'b0;
  int n_acc, n_dlv, n_done, dlv_in_frame, frame_total;
  int cyc = 0;
  int first_acc, first_dlv, last_dlv;
  logic          hold_v = 1'b0;
  logic [UW-1:0] hold_d;

  assign ac_upsp_rdata = ac_dat_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input logic [CW-1:0] s, input logic [CW-1:0] e);
    n_acc = 0; n_dlv = 0; n_done = 0; dlv_in_frame = 0;
    first_acc = -1; first_dlv = -1; last_dlv = -1;
    frame_total = int'(e) - int'(s) + 1;
    UPSTR = s; UPENDR = e; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (n_done == 0 && t < budget) begin
      tick(1);
      t++;
    end
    chk("done_seen", n_done != 0, 1);
  endtask

  // ac source: advances the data word after each accepted beat
  always @(posedge clk) begin
    #1;
    if (pending_acc) begin
      ac_dat_r = ac_dat_r + 1'b1;
      pending_acc = 1'b0;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (hold_v) begin
        chk("hold_valid", upsp_rvalid, 1);
        chk("hold_data", upsp_rdata, hold_d);
      end
      hold_v = upsp_rvalid && !upsp_rready;
      hold_d = upsp_rdata;
      if (upsp_rvalid && upsp_rready) begin
        n_dlv++;
        if (first_dlv < 0) first_dlv = cyc;
        last_dlv = cyc;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rdata", upsp_rdata, exp_q.pop_front());
`ifdef UPSP_RBUF_LAST_EN
        chk("rlast", upsp_rlast, (dlv_in_frame + 1 == frame_total));
`endif
        dlv_in_frame++;
      end
      if (ac_upsp_rvalid && upsp_ac_rready) begin
        exp_q.push_back(ac_upsp_rdata);
        n_acc++;
        pending_acc = 1'b1;
        if (first_acc < 0) first_acc = cyc;
      end
      if (done) begin
        n_done++;
        chk("busy_at_done", busy, 0);
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; UPSTR = '0; UPENDR = '0;
    ac_upsp_rvalid = 1'b0; upsp_rready = 1'b0; ac_dat_r = '0;
    n_acc = 0; n_dlv = 0; n_done = 0; dlv_in_frame = 0; frame_total = 0;
    first_acc = -1; first_dlv = -1; last_dlv = -1;
    tick(3);
    chk("rst_rready", upsp_ac_rready, 0);
    chk("rst_rvalid", upsp_rvalid, 0);
    chk("rst_rdata", upsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_level", level, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick(2);

    // Five-pixel window, both sides always ready
    ac_dat_r = 1; ac_upsp_rvalid = 1'b1; upsp_rready = 1'b1;
    begin_frame(0, 4);
    chk("t1_busy_run", busy, 1);
    wait_done(100);
    tick(2);
    chk("t1_dlv", n_dlv, 5);
    chk("t1_latency", first_dlv - first_acc, 1);
    chk("t1_span", last_dlv - first_dlv, 4);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Twenty-pixel window with consumer stalled, then full-FIFO boundary
    ac_dat_r = 1; upsp_rready = 1'b0;
    begin_frame(0, 19);
    tick(14);
    chk("t2_level_full", level, 8);
    chk("t2_rready_full", upsp_ac_rready, 0);
    chk("t2_acc8", n_acc, 8);
    upsp_rready = 1'b1;
    tick(1);
    chk("t4_level7", level, 7);
    chk("t4_no_acc", n_acc, 8);
    chk("t4_rready_back", upsp_ac_rready, 1);
    upsp_rready = 1'b0;
    tick(1);
    chk("t4_level8", level, 8);
    chk("t4_acc9", n_acc, 9);
    upsp_rready = 1'b1;
    wait_done(200);
    tick(2);
    chk("t2_dlv", n_dlv, 20);
    chk("t2_acc", n_acc, 20);
    chk("t2_done_cnt", n_done, 1);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Inverted window
    begin_frame(10, 9);
    chk("t3_err_hi", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_rready", upsp_ac_rready, 0);
    tick(1);
    chk("t3_err_lo", err, 0);
    chk("t3_state_idle", dbg_state, 0);
    tick(3);
    chk("t3_no_done", n_done, 0);
    chk("t3_no_acc", n_acc, 0);

    // Reset mid-run, then a single-pixel window
    ac_dat_r = 'h100; upsp_rready = 1'b0;
    begin_frame(0, 9);
    tick(3);
    chk("t5_level3", level, 3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rready", upsp_ac_rready, 0);
    chk("t5_rst_rvalid", upsp_rvalid, 0);
    chk("t5_rst_rdata", upsp_rdata, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_err", err, 0);
    chk("t5_rst_level", level, 0);
`ifdef UPSP_RBUF_LAST_EN
    chk("t5_rst_rlast", upsp_rlast, 0);
`endif
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    ac_dat_r = 'h77; upsp_rready = 1'b1;
    begin_frame(7, 7);
    wait_done(50);
    tick(2);
    chk("t5_dlv", n_dlv, 1);
    chk("t5_done_cnt", n_done, 1);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Second start while busy is ignored
    ac_dat_r = 'h200; upsp_rready = 1'b1;
    begin_frame(0, 5);
    tick(1);
    UPSTR = 0; UPENDR = 1; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t6_busy", busy, 1);
    wait_done(100);
    tick(3);
    chk("t6_dlv", n_dlv, 6);
    chk("t6_acc", n_acc, 6);
    chk("t6_done_cnt", n_done, 1);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_idle", dbg_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/upsp_ac_rbuf.md
Name: upsp_ac_rbuf

Overview:
Parametrised read-side buffer between the access-control (ac) read channel and the up-sampling (upsp) core.
- Fetches a programmed window of pixels, indices UPSTR..UPENDR inclusive, from ac.
- Stores them in a DEPTH-entry FIFO and presents them to upsp on a valid/ready port.
- Tracks frame progress and reports done/err, replacing the direct ac-to-upsp read wiring.

Parameters:
CRF_DATA_WIDTH, 32, width of config registers UPSTR/UPENDR and of internal beat counters
UPSP_DATA_WIDTH, 24, pixel word width on both ac and upsp sides
DEPTH, 8, FIFO entries; power of 2, >= 2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
UPSTR  in  CRF_DATA_WIDTH  first pixel index of window, sampled on start
UPENDR  in  CRF_DATA_WIDTH  last pixel index of window (inclusive), sampled on start
start  in  1  one-cycle pulse: begin a frame window
ac_upsp_rvalid  in  1  ac read data valid
ac_upsp_rdata  in  UPSP_DATA_WIDTH  ac read data
upsp_ac_rready  out  1  buffer accepts ac beat
upsp_rvalid  out  1  pixel available to upsp
upsp_rdata  out  UPSP_DATA_WIDTH  pixel to upsp
upsp_rready  in  1  upsp accepts pixel
busy  out  1  window in progress (RUN or DRAIN)
done  out  1  one-cycle pulse: all window pixels delivered
err  out  1  one-cycle pulse: start with UPENDR < UPSTR
level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values: upsp_ac_rready=0, upsp_rvalid=0, upsp_rdata=0, busy=0, done=0, err=0, level=0.
- Reset state: FSM=IDLE; FIFO pointers, acc_cnt and dlv_cnt cleared. Reset mid-frame discards all buffered data.
- Handshakes:
  - ac beat accepted when ac_upsp_rvalid && upsp_ac_rready.
  - upsp beat delivered when upsp_rvalid && upsp_rready.
  - upsp_rvalid, once high, is held together with stable upsp_rdata until delivered.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: upsp_ac_rready=0. On start:
    - UPENDR >= UPSTR: latch total = UPENDR-UPSTR+1 (CRF_DATA_WIDTH unsigned); clear acc_cnt and dlv_cnt; go to RUN.
    - UPENDR < UPSTR: err=1 for one cycle; stay IDLE.
  - RUN: upsp_ac_rready = (level < DEPTH) && (acc_cnt < total). It is combinational from registered state and does not depend on ac_upsp_rvalid. When the accepted beat makes acc_cnt == total, go to DRAIN.
  - DRAIN: upsp_ac_rready=0. When the delivered beat makes dlv_cnt == total (FIFO then empty), go to DONE.
  - DONE: done=1 for this one cycle; go to IDLE.
  - start is ignored outside IDLE.
  - busy=1 in RUN and DRAIN only.
- FIFO:
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full when level == DEPTH, empty when level == 0.
  - level: +1 on accept only, -1 on deliver only, unchanged on simultaneous accept and deliver.
  - Full with simultaneous deliver: no accept that cycle, because rready is computed from the pre-deliver level. No fall-through bypass.
- Latency:
  - Accepted beat appears on upsp_rvalid/upsp_rdata the next cycle when the FIFO was empty.
  - Sustained throughput is 1 beat/cycle when DEPTH >= 2 and both sides are always ready.
- Order: upsp_rdata sequence equals ac_upsp_rdata accept order.
- Window of one pixel (UPENDR == UPSTR) is legal: total = 1.

Optional Feature:
UPSP_RBUF_LAST_EN
- Defined:
  - Adds output port upsp_rlast (1 bit, reset 0), stored per FIFO entry.
  - Asserted with upsp_rvalid on the beat whose dlv_cnt+1 == total.
  - Low on all other beats.
- Undefined: port and extra storage bit absent; all other behaviour identical.

Test Plan:
1. Reset, then start with UPSTR=0, UPENDR=4; ac always valid, data 1..5; upsp always ready -> upsp_rdata 1,2,3,4,5 on consecutive cycles starting 1 cycle after first accept; done pulses once; busy falls with done.
2. DEPTH=8, UPSTR=0, UPENDR=19, upsp_rready=0 -> exactly 8 accepts, level=8, upsp_ac_rready=0. Raise rready -> remaining 12 accepted, 20 beats delivered in order, done=1.
3. start with UPSTR=10, UPENDR=9 -> err=1 for one cycle, busy stays 0, upsp_ac_rready stays 0.
4. Full FIFO with upsp_rready=1 and ac valid in the same cycle -> level goes 8->7 with no accept that cycle; accept next cycle, level back to 8.
5. Reset asserted mid-RUN with level=3 -> all outputs at reset values immediately. New start with UPSTR=UPENDR=7 -> single beat delivered, done pulse (upsp_rlast=1 on it when UPSP_RBUF_LAST_EN).
6. Second start pulse while busy -> ignored; total and counters unchanged; original frame completes normally.
